// File: rtl/matvec_pkg.sv
// matvec_pkg: shared definitions for the matvec tile scheduler.
// Holds the FSM state encoding, the tile edge length, and helpers for
// accumulator width, index width and signed saturation.
package matvec_pkg;

    localparam int TILE = 4;

    typedef enum logic [2:0] {IDLE, FETCH, WAIT, MAC, OUT} state_e;

    // Room for CT additions of DATA_WIDTH-bit signed terms plus a sign guard bit.
    function automatic int acc_w(input int dw, input int cols);
        return dw + $clog2(cols / TILE) + 1;
    endfunction

    // Index width that never collapses to zero bits for single-entry ranges.
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction

    function automatic int sat(input int v, input int dw);
        int hi;
        int lo;
        hi = (1 << (dw - 1)) - 1;
        lo = -(1 << (dw - 1));
        return v > hi ? hi : v < lo ? lo : v;
    endfunction

endpackage

// File: rtl/matvec_acc_lane.sv
// matvec_acc_lane: one signed accumulator lane of the tile scheduler.
// Ports: clk/rst (async active-high), clr_i clears the sum (wins over add_i),
// add_i adds sign-extended din_i, dout_o is the DATA_WIDTH-bit lane result.
// MATVEC_SAT_EN: when defined dout_o saturates, otherwise it wraps (truncates).
module matvec_acc_lane
    import matvec_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_W      = 11
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  add_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic [DATA_WIDTH-1:0] dout_o
);

    logic signed [ACC_W-1:0] acc_q, acc_d;

    always_comb acc_d = clr_i ? '0 : add_i ? acc_q + ACC_W'($signed(din_i)) : acc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

`ifdef MATVEC_SAT_EN
    assign dout_o = DATA_WIDTH'(sat(int'(acc_q), DATA_WIDTH));
`else
    assign dout_o = acc_q[DATA_WIDTH-1:0];
`endif

endmodule

// File: rtl/matvec_tile_sched.sv
// matvec_tile_sched: sequences 4x4 weight tiles and 4-element input slices
// through an external combinational MAC, accumulates per row tile and emits
// one 4-lane result per row tile over valid/ready.
// Ports: start_i/abort_i control, busy_o/done_o status; w_*/x_* buffer reads
// (data one cycle after the strobe); mul_a_o/mul_b_o/mul_c_i multiplier link;
// out_valid_o/out_ready_i/out_data_o/out_row_o result stream (lane 0 at MSB).
// MATVEC_SAT_EN: saturate lane results instead of wrap-around truncation.
module matvec_tile_sched
    import matvec_pkg::*;
#(
    parameter int ROWS       = 16,
    parameter int COLS       = 16,
    parameter int DATA_WIDTH = 8,
    localparam int RT    = ROWS / TILE,
    localparam int CT    = COLS / TILE,
    localparam int AW    = idx_w(RT * CT),
    localparam int XW    = idx_w(CT),
    localparam int RW    = idx_w(RT),
    localparam int ACC_W = acc_w(DATA_WIDTH, COLS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start_i,
    input  logic                              abort_i,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              w_rd_en_o,
    output logic [AW-1:0]                     w_addr_o,
    input  logic [TILE*TILE*DATA_WIDTH-1:0]   w_rdata_i,
    output logic                              x_rd_en_o,
    output logic [XW-1:0]                     x_addr_o,
    input  logic [TILE*DATA_WIDTH-1:0]        x_rdata_i,
    output logic [TILE*TILE*DATA_WIDTH-1:0]   mul_a_o,
    output logic [TILE*DATA_WIDTH-1:0]        mul_b_o,
    input  logic [TILE*DATA_WIDTH-1:0]        mul_c_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [TILE*DATA_WIDTH-1:0]        out_data_o,
    output logic [RW-1:0]                     out_row_o
);

    localparam logic [XW-1:0] CT_LAST = XW'(CT - 1);
    localparam logic [RW-1:0] RT_LAST = RW'(RT - 1);

    state_e                            state_q;
    logic [XW-1:0]                     ct_q;
    logic [RW-1:0]                     rt_q;
    logic                              done_q;
    logic [TILE*TILE*DATA_WIDTH-1:0]   mul_a_q;
    logic [TILE*DATA_WIDTH-1:0]        mul_b_q;
    logic                              clr;
    logic                              add;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ct_q    <= '0;
            rt_q    <= '0;
            done_q  <= 1'b0;
            mul_a_q <= '0;
            mul_b_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort_i) begin
                state_q <= IDLE;
                ct_q    <= '0;
                rt_q    <= '0;
            end else begin
                case (state_q)
                    IDLE: if (start_i) begin
                        state_q <= FETCH;
                        ct_q    <= '0;
                        rt_q    <= '0;
                    end
                    FETCH: state_q <= WAIT;
                    WAIT: begin
                        mul_a_q <= w_rdata_i;
                        mul_b_q <= x_rdata_i;
                        state_q <= MAC;
                    end
                    MAC: if (ct_q == CT_LAST) begin
                        state_q <= OUT;
                    end else begin
                        ct_q    <= ct_q + XW'(1);
                        state_q <= FETCH;
                    end
                    OUT: if (out_ready_i) begin
                        ct_q <= '0;
                        // Counters return to zero at the end so IDLE addresses read 0.
                        if (rt_q == RT_LAST) begin
                            rt_q    <= '0;
                            done_q  <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            rt_q    <= rt_q + RW'(1);
                            state_q <= FETCH;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy_o      = state_q != IDLE;
    assign done_o      = done_q;
    assign w_rd_en_o   = state_q == FETCH;
    assign x_rd_en_o   = state_q == FETCH;
    assign w_addr_o    = AW'(rt_q) * AW'(CT) + AW'(ct_q);
    assign x_addr_o    = ct_q;
    assign mul_a_o     = mul_a_q;
    assign mul_b_o     = mul_b_q;
    assign out_valid_o = state_q == OUT;
    assign out_row_o   = rt_q;

    // Lane sums restart at a new pass, after each accepted row tile, and on abort.
    assign clr = abort_i || (state_q == IDLE && start_i) || (state_q == OUT && out_ready_i);
    assign add = !abort_i && state_q == MAC;

    for (genvar i = 0; i < TILE; i++) begin : g_lane
        matvec_acc_lane #(
            .DATA_WIDTH(DATA_WIDTH),
            .ACC_W     (ACC_W)
        ) u_lane (
            .clk   (clk),
            .rst   (rst),
            .clr_i (clr),
            .add_i (add),
            .din_i (mul_c_i[(TILE-1-i)*DATA_WIDTH +: DATA_WIDTH]),
            .dout_o(out_data_o[(TILE-1-i)*DATA_WIDTH +: DATA_WIDTH])
        );
    end

endmodule

// File: tb/tb_matvec_tile_sched.sv
// tb_matvec_tile_sched: randomized directed bench for matvec_tile_sched (16x16, 8-bit).
module tb_matvec_tile_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         abort;
    logic         busy;
    logic         done;
    logic         w_rd_en;
    logic [3:0]   w_addr;
    logic [127:0] w_rdata = '0;
    logic         x_rd_en;
    logic [1:0]   x_addr;
    logic [31:0]  x_rdata = '0;
    logic [127:0] mul_a;
    logic [31:0]  mul_b;
    logic [31:0]  mul_c;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_row;

    int compared   = 0;
    int mismatched = 0;

    int           wm [16][16];
    int           xv [16];
    logic [127:0] w_mem [16];
    logic [31:0]  x_mem [4];
    logic [31:0]  exp_data [4];

    matvec_tile_sched #(.ROWS(16), .COLS(16), .DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start),
        .abort_i    (abort),
        .busy_o     (busy),
        .done_o     (done),
        .w_rd_en_o  (w_rd_en),
        .w_addr_o   (w_addr),
        .w_rdata_i  (w_rdata),
        .x_rd_en_o  (x_rd_en),
        .x_addr_o   (x_addr),
        .x_rdata_i  (x_rdata),
        .mul_a_o    (mul_a),
        .mul_b_o    (mul_b),
        .mul_c_i    (mul_c),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (out_data),
        .out_row_o  (out_row)
    );

    always #5 clk = ~clk;

    // Buffers answer one cycle after the read strobe.
    always @(posedge clk) begin
        if (w_rd_en) w_rdata <= w_mem[w_addr];
        if (x_rd_en) x_rdata <= x_mem[x_addr];
    end

    // Multiplier stand-in: per lane, dot product of a tile row with the slice, wrapped to 8 bits.
    function automatic logic [31:0] mac_model(input logic [127:0] a, input logic [31:0] b);
        logic [31:0] r;
        int p;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            p = 0;
            for (int j = 0; j < 4; j++)
                p += int'($signed(a[(15-(i*4+j))*8 +: 8])) * int'($signed(b[(3-j)*8 +: 8]));
            r[(3-i)*8 +: 8] = p[7:0];
        end
        return r;
    endfunction

    assign mul_c = mac_model(mul_a, mul_b);

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        compared++;
        assert (obs === exp_v) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // New random matrix/vector, packed into tile memories, plus expected row-tile results.
    task automatic build_data();
        int s, p, e, v;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) wm[r][c] = int'($urandom_range(0, 255)) - 128;
        for (int c = 0; c < 16; c++) xv[c] = int'($urandom_range(0, 255)) - 128;
        for (int rt = 0; rt < 4; rt++)
            for (int ct = 0; ct < 4; ct++)
                for (int i = 0; i < 4; i++)
                    for (int j = 0; j < 4; j++) begin
                        v = wm[rt*4+i][ct*4+j];
                        w_mem[rt*4+ct][(15-(i*4+j))*8 +: 8] = v[7:0];
                    end
        for (int ct = 0; ct < 4; ct++)
            for (int j = 0; j < 4; j++) begin
                v = xv[ct*4+j];
                x_mem[ct][(3-j)*8 +: 8] = v[7:0];
            end
        for (int rt = 0; rt < 4; rt++)
            for (int i = 0; i < 4; i++) begin
                s = 0;
                for (int ct = 0; ct < 4; ct++) begin
                    p = 0;
                    for (int j = 0; j < 4; j++) p += wm[rt*4+i][ct*4+j] * xv[ct*4+j];
                    s += int'(byte'(p));
                end
`ifdef MATVEC_SAT_EN
                e = s > 127 ? 127 : s < -128 ? -128 : s;
`else
                e = s;
`endif
                exp_data[rt][(3-i)*8 +: 8] = e[7:0];
            end
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_busy"}, 128'(busy), 128'(0));
        check({pfx, "_done"}, 128'(done), 128'(0));
        check({pfx, "_w_rd_en"}, 128'(w_rd_en), 128'(0));
        check({pfx, "_x_rd_en"}, 128'(x_rd_en), 128'(0));
        check({pfx, "_w_addr"}, 128'(w_addr), 128'(0));
        check({pfx, "_x_addr"}, 128'(x_addr), 128'(0));
        check({pfx, "_mul_a"}, mul_a, 128'(0));
        check({pfx, "_mul_b"}, 128'(mul_b), 128'(0));
        check({pfx, "_out_valid"}, 128'(out_valid), 128'(0));
        check({pfx, "_out_data"}, 128'(out_data), 128'(0));
        check({pfx, "_out_row"}, 128'(out_row), 128'(0));
    endtask

    // One full pass. Inputs change at negedge; a handshake is counted when
    // valid and the ready value about to be sampled are both high.
    task automatic run_pass(input int rdy_pct, input bit poke_start, input bit timed);
        int cyc, fetches, rows;
        bit hs_now, hs_last, holding, seen, fin;
        logic [31:0] hold_d;
        logic [1:0]  hold_r;
        build_data();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; fetches = 0; rows = 0;
        hs_last = 0; holding = 0; seen = 0; fin = 0;
        hold_d = '0; hold_r = '0;
        while (!fin && cyc < 2000) begin
            check("done", 128'(done), 128'(hs_last));
            check("busy", 128'(busy), 128'(!hs_last));
            if (hs_last) begin
                if (timed) check("pass_cycles", 128'(cyc), 128'(52));
                check("idle_valid", 128'(out_valid), 128'(0));
                fin = 1;
            end else begin
                if (holding) begin
                    check("hold_valid", 128'(out_valid), 128'(1));
                    check("hold_data", 128'(out_data), 128'(hold_d));
                    check("hold_row", 128'(out_row), 128'(hold_r));
                    check("hold_no_fetch", 128'(w_rd_en), 128'(0));
                end
                if (w_rd_en) begin
                    check("w_addr", 128'(w_addr), 128'(fetches));
                    check("x_rd_en", 128'(x_rd_en), 128'(1));
                    check("x_addr", 128'(x_addr), 128'(fetches % 4));
                    fetches++;
                end
                if (out_valid) begin
                    if (timed && !seen) check("first_valid_cyc", 128'(cyc), 128'(12));
                    seen = 1;
                    check("out_row", 128'(out_row), 128'(rows));
                    check("out_data", 128'(out_data), 128'(exp_data[rows & 3]));
                end
                out_ready = $urandom_range(0, 99) < rdy_pct;
                start = poke_start && cyc == 5;
                hs_now = out_valid && out_ready;
                holding = out_valid && !out_ready;
                hold_d = out_data;
                hold_r = out_row;
                if (hs_now) rows++;
                hs_last = hs_now && rows == 4;
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        if (!fin) check("pass_timeout", 128'(rows), 128'(5));
        check("fetch_count", 128'(fetches), 128'(16));
    endtask

    initial begin
        int n, k;
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
        for (int t = 0; t < 16; t++) w_mem[t] = '0;
        for (int t = 0; t < 4; t++) x_mem[t] = '0;
        repeat (2) @(negedge clk);
        check_reset("rst_hold");
        rst = 1'b0;
        @(negedge clk);
        check_reset("post_rst");

        run_pass(100, 1'b0, 1'b1);
        run_pass(45, 1'b1, 1'b0);

        // Abort in the MAC cycle of the second column tile.
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0; k = 0;
        while (n < 2 && k < 100) begin
            if (w_rd_en) n++;
            if (n < 2) begin
                @(negedge clk);
                k++;
            end
        end
        check("abort_reach", 128'(n), 128'(2));
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_valid", 128'(out_valid), 128'(0));
        check("abort_rd", 128'(w_rd_en), 128'(0));
        check("abort_done", 128'(done), 128'(0));
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", 128'(done), 128'(0));
            check("abort_idle", 128'(busy), 128'(0));
        end
        run_pass(100, 1'b0, 1'b1);

        // Asynchronous reset while waiting on buffer data.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("rst_test_fetch", 128'(w_rd_en), 128'(1));
        @(negedge clk);
        #1 rst = 1'b1;
        #1 check_reset("async_rst");
        @(negedge clk);
        rst = 1'b0;
        run_pass(70, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
